mmio_host_dev: RTL and testbench

- Memory-mapped responder on the CPU data-memory bus. It uses the same request/response protocol as the data cache: r_v/w_v/adr/data/strobe in, resp/resp_valid out.
- Provides the simulation and host services the core needs:
  - a program-exit register,
  - a console byte stream drained through a valid/ready FIFO,
  - a coherent 64-bit cycle counter.
- Sits in parallel with the dmem cache and answers only inside its own 32-byte address window.

---
 rtl/mmio_host_dev_pkg.sv | 34 +++
 rtl/sync_fifo.sv | 51 +++++
 rtl/mmio_host_dev.sv | 123 ++++++++++++
 tb/tb_mmio_host_dev.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mmio_host_dev_pkg.sv
// Shared constants for the host-services MMIO block: register offsets, STATUS bit layout.
package mmio_host_dev_pkg;

  // Bus data/address width of the core.
  localparam int unsigned XLEN = 32;

  // Word offsets (adr[4:2]) inside the 32-byte window.
  localparam logic [2:0] MMIO_EXIT     = 3'd0;
  localparam logic [2:0] MMIO_CONSOLE  = 3'd1;
  localparam logic [2:0] MMIO_STATUS   = 3'd2;
  localparam logic [2:0] MMIO_CYCLE_LO = 3'd3;
  localparam logic [2:0] MMIO_CYCLE_HI = 3'd4;

  // STATUS register layout.
  localparam int unsigned STATUS_EMPTY_BIT = 0;
  localparam int unsigned STATUS_FULL_BIT  = 1;
  localparam int unsigned STATUS_OVF_BIT   = 2;
  localparam int unsigned STATUS_COUNT_LSB = 8;

  // Pack the STATUS word; occupancy is carried in an 8-bit field.
  function automatic logic [XLEN-1:0] status_word(input logic       empty,
                                                   input logic       full,
                                                   input logic       ovf,
                                                   input logic [7:0] count);
    logic [XLEN-1:0] w;
    w = '0;
    w[STATUS_EMPTY_BIT] = empty;
    w[STATUS_FULL_BIT] = full;
    w[STATUS_OVF_BIT] = ovf;
    w[STATUS_COUNT_LSB +: 8] = count;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO; a push while full is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int unsigned width = 8,
  parameter int unsigned depth = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [width-1:0]       wdata,
  input  logic                   pop,
  output logic [width-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(depth):0] count
);

  localparam int unsigned AddrW = $clog2(depth);
  localparam logic [AddrW:0] DepthCnt = (AddrW + 1)'(depth);

  logic [width-1:0] mem_q [depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             do_push, do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DepthCnt);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Pointer and occupancy bookkeeping; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage; contents are don't-care while empty so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/mmio_host_dev.sv
// Host-services MMIO responder: EXIT register, console FIFO, coherent 64-bit cycle counter.
module mmio_host_dev
  import mmio_host_dev_pkg::*;
#(
  parameter int unsigned     xlen         = XLEN,
  parameter logic [xlen-1:0] base_address = 32'h30000,
  parameter int unsigned     fifo_depth   = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            r_v,
  input  logic            w_v,
  input  logic [xlen-1:0] adr,
  input  logic [xlen-1:0] data,
  input  logic [3:0]      strobe,
  output logic [xlen-1:0] resp,
  output logic            resp_valid,
  output logic [7:0]      tx_data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            exit_v,
  output logic [xlen-1:0] exit_code
);

  localparam int unsigned CntW = $clog2(fifo_depth) + 1;

  logic            resp_valid_q, exit_v_q;
  logic [xlen-1:0] resp_q, exit_code_q, exit_code_d;
  logic [xlen-1:0] cyc_hi_q;
  logic [63:0]     cycle_q;
  logic            ovf_q, ovf_d;

  logic            hit, is_wr, is_rd;
  logic [2:0]      off;
  logic [xlen-1:0] rd_data;
  logic            push, pop, ovf_set, ovf_clr, snap_hi;
  logic            fifo_full, fifo_empty;
  logic [7:0]      fifo_head;
  logic [CntW-1:0] fifo_count;

  // Byte offset within a word plays no part in decode.
  logic unused_adr;
  assign unused_adr = ^adr[1:0];

  assign hit   = (r_v | w_v) & (adr[xlen-1:5] == base_address[xlen-1:5]);
  assign off   = adr[4:2];
  assign is_wr = hit & w_v;           // write wins when both r_v and w_v are set
  assign is_rd = hit & ~w_v;

  assign pop     = ~fifo_empty & tx_ready;
  assign push    = is_wr & (off == MMIO_CONSOLE) & strobe[0];
  // A full FIFO still accepts a push when a pop drains a slot in the same cycle.
  assign ovf_set = push & fifo_full & ~pop;
  assign ovf_clr = is_wr & (off == MMIO_STATUS) & strobe[0] & data[STATUS_OVF_BIT];
  assign snap_hi = is_rd & (off == MMIO_CYCLE_LO);

  // Read mux, EXIT byte merge and overflow next-state.
  always_comb begin
    rd_data = '0;
    case (off)
      MMIO_EXIT:     rd_data = exit_code_q;
      MMIO_STATUS:   rd_data = status_word(fifo_empty, fifo_full, ovf_q, 8'(fifo_count));
      MMIO_CYCLE_LO: rd_data = cycle_q[31:0];
      MMIO_CYCLE_HI: rd_data = cyc_hi_q;
      default:       rd_data = '0;
    endcase

    exit_code_d = exit_code_q;
    if (is_wr && off == MMIO_EXIT) begin
      for (int i = 0; i < 4; i++) begin
        if (strobe[i]) exit_code_d[8*i +: 8] = data[8*i +: 8];
      end
    end

    ovf_d = ovf_q;
    if (ovf_set) ovf_d = 1'b1;
    if (ovf_clr) ovf_d = 1'b0;
  end

  // Registered response path, EXIT, overflow flag, counter and hi snapshot.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      resp_valid_q <= 1'b0;
      resp_q       <= '0;
      exit_v_q     <= 1'b0;
      exit_code_q  <= '0;
      ovf_q        <= 1'b0;
      cycle_q      <= '0;
      cyc_hi_q     <= '0;
    end else begin
      resp_valid_q <= hit;
      resp_q       <= is_rd ? rd_data : '0;
      exit_v_q     <= is_wr & (off == MMIO_EXIT);
      exit_code_q  <= exit_code_d;
      ovf_q        <= ovf_d;
      cycle_q      <= cycle_q + 64'd1;
      if (snap_hi) cyc_hi_q <= cycle_q[63:32];
    end
  end

  sync_fifo #(
    .width (8),
    .depth (fifo_depth)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata (data[7:0]),
    .pop   (pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign resp       = resp_q;
  assign resp_valid = resp_valid_q;
  assign exit_v     = exit_v_q;
  assign exit_code  = exit_code_q;
  assign tx_valid   = ~fifo_empty;
  assign tx_data    = fifo_empty ? 8'h00 : fifo_head;

endmodule

// File: tb/tb_mmio_host_dev.sv
// Randomised bench for mmio_host_dev against a queue-based behavioural model.
module tb_mmio_host_dev;

  localparam logic [31:0] BASE  = 32'h30000;
  localparam int          DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        r_v, w_v;
  logic [31:0] adr, data;
  logic [3:0]  strobe;
  logic [31:0] resp;
  logic        resp_valid;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        exit_v;
  logic [31:0] exit_code;

  always #5 clk = ~clk;

  mmio_host_dev #(
    .xlen         (32),
    .base_address (BASE),
    .fifo_depth   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .r_v        (r_v),
    .w_v        (w_v),
    .adr        (adr),
    .data       (data),
    .strobe     (strobe),
    .resp       (resp),
    .resp_valid (resp_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .exit_v     (exit_v),
    .exit_code  (exit_code)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  logic [7:0]  m_q[$];
  logic [31:0] m_exit;
  bit          m_ovf;
  logic [63:0] m_cyc;
  logic [31:0] m_hi;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_exit = '0;
    m_ovf  = 1'b0;
    m_cyc  = '0;
    m_hi   = '0;
  endtask

  // One clock: drive a request, advance the model, then check everything the DUT shows after the edge.
  task automatic step(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input bit rdy);
    bit          hit, exp_exitv, pop, push;
    int          off, sz;
    logic [31:0] exp_resp;
    r_v = r; w_v = w; adr = a; data = d; strobe = s; tx_ready = rdy;
    hit = (r || w) && (a[31:5] == BASE[31:5]);
    off = int'(a[4:2]);
    sz  = m_q.size();
    exp_resp = '0;
    if (hit && !w) begin
      case (off)
        0: exp_resp = m_exit;
        2: exp_resp = {16'h0, 8'(sz), 5'h0, m_ovf, (sz == DEPTH), (sz == 0)};
        3: exp_resp = m_cyc[31:0];
        4: exp_resp = m_hi;
        default: exp_resp = '0;
      endcase
    end
    exp_exitv = hit && w && off == 0;
    if (hit && !w && off == 3) m_hi = m_cyc[63:32];
    if (exp_exitv)
      for (int i = 0; i < 4; i++) if (s[i]) m_exit[8*i +: 8] = d[8*i +: 8];
    pop  = (sz > 0) && rdy;
    push = hit && w && off == 1 && s[0];
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (sz < DEPTH || pop) m_q.push_back(d[7:0]);
      else m_ovf = 1'b1;
    end
    if (hit && w && off == 2 && s[0] && d[2]) m_ovf = 1'b0;
    m_cyc = m_cyc + 64'd1;
    @(posedge clk); #1;
    check("resp_valid", resp_valid, hit);
    if (hit) check("resp", resp, exp_resp);
    check("exit_v", exit_v, exp_exitv);
    check("exit_code", exit_code, m_exit);
    check("tx_valid", tx_valid, m_q.size() > 0);
    if (m_q.size() > 0) check("tx_data", tx_data, m_q[0]);
  endtask

  task automatic idle(input bit rdy);
    step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0, rdy);
  endtask

  initial begin
    logic [31:0] a;
    int          off;
    bit          r, w;

    rst_n = 1'b0; r_v = 1'b0; w_v = 1'b0; adr = '0; data = '0; strobe = '0; tx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    check("rst_resp_valid", resp_valid, 1'b0);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_exit_code", exit_code, 32'h0);

    // STATUS read after reset, then an out-of-window read.
    step(1, 0, BASE + 32'h8, 0, 0, 0);
    check("status_empty", resp, 32'h1);
    step(1, 0, 32'h20008, 0, 0, 0);
    check("miss_no_resp", resp_valid, 1'b0);

    // EXIT writes with byte merge.
    step(0, 1, BASE, 32'h2A, 4'hF, 0);
    step(0, 1, BASE, 32'h0000FF00, 4'h2, 0);
    check("exit_merge", exit_code, 32'hFF2A);
    step(1, 0, BASE, 0, 0, 0);

    // Overfill the console FIFO, drain it, clear overflow.
    for (int i = 0; i < 17; i++) step(0, 1, BASE + 32'h4, 32'h41 + i, 4'h1, 0);
    step(1, 0, BASE + 32'h8, 0, 0, 0);
    check("status_full_ovf", resp, 32'h1006);
    for (int i = 0; i < 16; i++) begin
      check("drain_order", tx_data, 8'(8'h41 + i));
      idle(1);
    end
    step(0, 1, BASE + 32'h8, 32'h4, 4'h1, 0);
    step(1, 0, BASE + 32'h8, 0, 0, 0);
    check("ovf_cleared", resp, 32'h1);

    // Push and pop on a full FIFO in the same cycle.
    for (int i = 0; i < 16; i++) step(0, 1, BASE + 32'h4, 32'h60 + i, 4'h1, 0);
    step(0, 1, BASE + 32'h4, 32'h99, 4'h1, 1);
    step(1, 0, BASE + 32'h8, 0, 0, 0);
    check("full_push_pop", resp, 32'h1002);
    for (int i = 0; i < 16; i++) idle(1);
    check("drained", tx_valid, 1'b0);

    // Randomised traffic, back-to-back.
    for (int k = 0; k < 800; k++) begin
      off = $urandom_range(0, 9);
      if (off > 7) off = 1;
      if ($urandom_range(0, 99) < 90) a = {BASE[31:5], 3'(off), 2'($urandom_range(0, 3))};
      else a = $urandom;
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      step(r, w, a, $urandom, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) == 0));
    end
    for (int i = 0; i < 20; i++) idle(1);

    // Coherent 64-bit read across a low-word carry.
    force dut.cycle_q = 64'h0000_0001_FFFF_FFFE;
    #1;
    release dut.cycle_q;
    m_cyc = 64'h0000_0001_FFFF_FFFE;
    step(1, 0, BASE + 32'hC, 0, 0, 0);
    check("cyc_lo", resp, 32'hFFFF_FFFE);
    repeat (4) idle(0);
    step(1, 0, BASE + 32'h10, 0, 0, 0);
    check("cyc_hi_snapshot", resp, 32'h1);
    check("cyc_hi_live", dut.cycle_q[63:32], 32'h2);

    // Reset with a request in flight and a non-empty FIFO.
    step(0, 1, BASE + 32'h4, 32'h77, 4'h1, 0);
    step(0, 1, BASE + 32'h4, 32'h78, 4'h1, 0);
    rst_n = 1'b0; r_v = 1'b0; w_v = 1'b1; adr = BASE + 32'h4; data = 32'h55; strobe = 4'h1;
    tx_ready = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    check("rst2_resp_valid", resp_valid, 1'b0);
    check("rst2_tx_valid", tx_valid, 1'b0);
    check("rst2_exit_code", exit_code, 32'h0);
    step(1, 0, BASE + 32'h8, 0, 0, 0);
    check("rst2_status", resp, 32'h1);
    step(1, 0, BASE + 32'hC, 0, 0, 0);
    check("rst2_cycle", resp, 32'h1);
    idle(0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
